local_mem_bank_arbiter: RTL and testbench
=========================================

// Module: local_mem_bank_arbiter
// PURPOSE
//  Shares one Avalon-MM local-memory bank (one local_mem[] port) between NUM_REQ AFU-side
//  requesters. Round-robin command arbitration, write-burst grant lock, and in-order read
//  response routing through a tag FIFO. One instance sits in front of each bank.
// PARAMETERS
//  NUM_REQ      2    requester count (2..8)
//  ADDR_W       27   word address width
//  DATA_W       512  data width; byteenable is DATA_W/8
//  BURST_W      7    burstcount width; legal burstcount 1..2**(BURST_W-1)
//  RSP_DEPTH    64   outstanding read bursts tracked (power of 2)
// PORTS
//  pClk                 in   1                     clock
//  pck_cp2af_softReset  in   1                     reset, asynchronous, active-high
//  req_read             in   NUM_REQ               per-requester read command
//  req_write            in   NUM_REQ               per-requester write beat
//  req_address          in   NUM_REQ*ADDR_W        packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_burstcount       in   NUM_REQ*BURST_W       packed burstcount
//  req_writedata        in   NUM_REQ*DATA_W        packed write data
//  req_byteenable       in   NUM_REQ*DATA_W/8      packed byte enables
//  req_waitrequest      out  NUM_REQ               1 = command/beat not accepted this cycle
//  req_readdata         out  DATA_W                shared read data bus
//  req_readdatavalid    out  NUM_REQ               one-hot read beat valid
//  m_address/m_burstcount/m_writedata/m_byteenable  out  --  muxed winner fields to bank
//  m_read, m_write      out  1                     bank command
//  m_waitrequest        in   1                     bank back-pressure
//  m_readdata           in   DATA_W                bank read data
//  m_readdatavalid      in   1                     bank read beat valid
//  err_unexpected_rsp   out  1                     sticky: readdatavalid with no tag queued
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, tag FIFO empty, beat counter 0; m_read=m_write=0,
//   req_waitrequest all 1, req_readdatavalid 0, err_unexpected_rsp 0. Reset mid-burst or
//   with reads outstanding discards all state; in-flight responses after reset raise err.
//  Arbitration (IDLE): eligible i = req_write[i] | (req_read[i] & !fifo_full). Winner = first
//   eligible searching ptr, ptr+1, .. mod NUM_REQ. Combinational: winner fields drive m_*,
//   m_read/m_write = winner's read/write, req_waitrequest[winner] = m_waitrequest, others 1.
//   No added command latency. ptr <= winner+1 only when command accepted (cmd & !m_waitrequest).
//  Requester asserting read and write together: write wins; read is held.
//  Write burst: accepted first beat with burstcount B>1 -> state WR_LOCK(owner, rem=B-1).
//   WR_LOCK: only owner's req_write is forwarded; owner's req_read ignored; others waited.
//   Each accepted beat decrements rem; rem 1->0 returns to IDLE next cycle. ptr advances on
//   first beat. burstcount on beats 2..B is don't-care (first-beat value forwarded).
//  Reads: accepted read pushes {id, burstcount} into tag FIFO (RSP_DEPTH entries). fifo_full
//   masks read eligibility only; writes still arbitrate.
//  Responses: m_readdatavalid -> req_readdatavalid[head.id]=1 same cycle (combinational),
//   req_readdata = m_readdata. Beat counter counts to head.burstcount; pop on last beat.
//   Push and pop in same cycle allowed; full flag honours simultaneous pop (no bubble).
//   m_readdatavalid with FIFO empty: no valid issued, err_unexpected_rsp <= 1 until reset.
//  Burstcount 0 is illegal input; treated as 1.
// TESTING
//  1 Reset: assert reset async mid-cycle -> all req_waitrequest=1, m_read=m_write=0 immediately.
//  2 Both req0/req1 issue reads back-to-back, m_waitrequest=0 -> grants 0,1,0,1; bank returns
//    4 beats -> readdatavalid one-hot 01,10,01,10 in order.
//  3 req0 write burst B=4, req1 read pending -> 4 req0 beats consecutive, req1 waitrequest=1
//    throughout, req1 read accepted on the cycle after beat 4.
//  4 Fill RSP_DEPTH=64 reads with no responses -> 65th read waits, concurrent write accepted;
//    one response beat (burst 1) -> read accepted that same cycle.
//  5 m_waitrequest=1 for 10 cycles with req0,req1 active -> ptr unchanged, m_* stable, no push.
//  6 m_readdatavalid with empty FIFO -> no req_readdatavalid, err_unexpected_rsp=1 and sticks.

Source files
------------

// File: rtl/local_mem_bank_arbiter_if.sv
// Requester-side and bank-side signals of one local-memory bank arbiter.
// The master modport is the environment (requesters plus bank). The slave modport is the arbiter.
interface local_mem_bank_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 7
);
  logic [NUM_REQ-1:0]          req_read;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*ADDR_W-1:0]   req_address;
  logic [NUM_REQ*BURST_W-1:0]  req_burstcount;
  logic [NUM_REQ*DATA_W-1:0]   req_writedata;
  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable;
  logic [NUM_REQ-1:0]          req_waitrequest;
  logic [DATA_W-1:0]           req_readdata;
  logic [NUM_REQ-1:0]          req_readdatavalid;
  logic [ADDR_W-1:0]           m_address;
  logic [BURST_W-1:0]          m_burstcount;
  logic [DATA_W-1:0]           m_writedata;
  logic [DATA_W/8-1:0]         m_byteenable;
  logic                        m_read;
  logic                        m_write;
  logic                        m_waitrequest;
  logic [DATA_W-1:0]           m_readdata;
  logic                        m_readdatavalid;
  logic                        err_unexpected_rsp;

  modport master (
    output req_read, req_write, req_address, req_burstcount, req_writedata, req_byteenable,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  m_address, m_burstcount, m_writedata, m_byteenable, m_read, m_write,
    output m_waitrequest, m_readdata, m_readdatavalid,
    input  err_unexpected_rsp
  );

  modport slave (
    input  req_read, req_write, req_address, req_burstcount, req_writedata, req_byteenable,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output m_address, m_burstcount, m_writedata, m_byteenable, m_read, m_write,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    output err_unexpected_rsp
  );
endinterface

// File: rtl/local_mem_bank_arbiter.sv
// Round-robin share of one memory bank with write-burst lock and in-order read steering.
// Commands and responses pass through with zero latency. Bank waitrequest goes back to the winner only.
module local_mem_bank_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 512,
  parameter int BURST_W   = 7,
  parameter int RSP_DEPTH = 64
) (
  input logic                     pClk,
  input logic                     pck_cp2af_softReset,
  local_mem_bank_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {IDLE, WR_LOCK} state_t;
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BURST_W-1:0] bc;
  } tag_t;

  logic rst;
  assign rst = pck_cp2af_softReset;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, owner, win, sel;
  logic               win_vld;
  logic [BURST_W-1:0] rem, lock_bc, beat_cnt;
  logic [NUM_REQ-1:0] elig;
  logic               cmd_acc, push, pop, full, empty, last_beat, err_q;
  tag_t               tag_mem [RSP_DEPTH];
  tag_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic [ADDR_W-1:0]  addr_a [NUM_REQ];
  logic [BURST_W-1:0] bc_a   [NUM_REQ];
  logic [DATA_W-1:0]  wdat_a [NUM_REQ];
  logic [BE_W-1:0]    be_a   [NUM_REQ];

  // Burstcount 0 is folded to 1 here so everything downstream sees a legal length.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    logic [BURST_W-1:0] raw_bc;
    assign raw_bc    = bus.req_burstcount[g*BURST_W +: BURST_W];
    assign addr_a[g] = bus.req_address[g*ADDR_W +: ADDR_W];
    assign bc_a[g]   = (raw_bc == '0) ? BURST_W'(1) : raw_bc;
    assign wdat_a[g] = bus.req_writedata[g*DATA_W +: DATA_W];
    assign be_a[g]   = bus.req_byteenable[g*BE_W +: BE_W];
  end

  assign full      = (count == (PTR_W+1)'(RSP_DEPTH));
  assign empty     = (count == '0);
  assign head      = tag_mem[rd_ptr];
  assign last_beat = (beat_cnt == head.bc - BURST_W'(1));
  assign pop       = bus.m_readdatavalid & !empty & last_beat;
  // A pop in the same cycle frees a slot, so a full FIFO does not block the read.
  assign elig      = bus.req_write | (bus.req_read & {NUM_REQ{!(full & !pop)}});

  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (elig[ID_W'(idx)]) begin
        win_vld = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  assign cmd_acc = (bus.m_read | bus.m_write) & !bus.m_waitrequest;
  assign push    = cmd_acc & bus.m_read;

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_acc && bus.m_write && bus.m_burstcount > BURST_W'(1)) state_nxt = WR_LOCK;
      WR_LOCK: if (cmd_acc && rem == BURST_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel         = (state == WR_LOCK) ? owner : win;
    bus.m_write = 1'b0;
    bus.m_read  = 1'b0;
    if (!rst) begin
      if (state == WR_LOCK) begin
        bus.m_write = bus.req_write[owner];
      end else if (win_vld) begin
        bus.m_write = bus.req_write[win];
        bus.m_read  = !bus.req_write[win];
      end
    end
    bus.m_address    = addr_a[sel];
    bus.m_burstcount = (state == WR_LOCK) ? lock_bc : bc_a[sel];
    bus.m_writedata  = wdat_a[sel];
    bus.m_byteenable = be_a[sel];
    bus.req_waitrequest = '1;
    if (bus.m_read || bus.m_write) bus.req_waitrequest[sel] = bus.m_waitrequest;
    bus.req_readdatavalid = '0;
    if (!rst && bus.m_readdatavalid && !empty) bus.req_readdatavalid[head.id] = 1'b1;
  end

  assign bus.req_readdata       = bus.m_readdata;
  assign bus.err_unexpected_rsp = err_q;

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      owner   <= '0;
      rem     <= '0;
      lock_bc <= '0;
    end else if (cmd_acc) begin
      if (state == IDLE) begin
        ptr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
        owner   <= win;
        rem     <= bus.m_burstcount - BURST_W'(1);
        lock_bc <= bus.m_burstcount;
      end else begin
        rem <= rem - BURST_W'(1);
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (push) tag_mem[wr_ptr] <= {win, bus.m_burstcount};
  end

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (bus.m_readdatavalid) begin
        if (empty) err_q    <= 1'b1;
        else       beat_cnt <= last_beat ? '0 : beat_cnt + BURST_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_local_mem_bank_arbiter.sv
// Directed bench for local_mem_bank_arbiter with hand-computed expected grants and responses.
module tb_local_mem_bank_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 27;
  localparam int DATA_W    = 512;
  localparam int BURST_W   = 7;
  localparam int RSP_DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  local_mem_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                              .BURST_W(BURST_W)) bus ();

  local_mem_bank_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .BURST_W(BURST_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .pClk                (clk),
    .pck_cp2af_softReset (rst),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bc(input int b0, input int b1);
    bus.req_burstcount = {BURST_W'(b1), BURST_W'(b0)};
  endtask

  initial begin
    int n;
    bus.req_read        = '0;
    bus.req_write       = '0;
    bus.req_address     = {ADDR_W'(27'h200), ADDR_W'(27'h100)};
    bus.req_writedata   = {DATA_W'(64'hB1), DATA_W'(64'hA0)};
    bus.req_byteenable  = '1;
    bus.m_waitrequest   = 1'b0;
    bus.m_readdata      = '0;
    bus.m_readdatavalid = 1'b0;
    set_bc(1, 1);
    #3;
    check("rst_wait", bus.req_waitrequest, 2'b11);
    check("rst_cmd", {bus.m_read, bus.m_write}, 2'b00);
    check("rst_rdv", bus.req_readdatavalid, 2'b00);
    check("rst_err", bus.err_unexpected_rsp, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Alternating read grants, then in-order one-hot responses.
    bus.req_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", bus.req_waitrequest, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_addr", bus.m_address, (i % 2 == 0) ? 27'h100 : 27'h200);
      tick();
    end
    bus.req_read = 2'b00;
    bus.m_readdatavalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.m_readdata = DATA_W'(64'hD0 + i);
      #1;
      check("rsp_onehot", bus.req_readdatavalid, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rsp_data", bus.req_readdata[63:0], 64'hD0 + i);
      tick();
    end
    bus.m_readdatavalid = 1'b0;

    // Write burst of 4 from req0 locks out req1's read.
    bus.req_write = 2'b01;
    bus.req_read  = 2'b10;
    set_bc(4, 2);
    #1;
    check("wr_first_grant", bus.req_waitrequest, 2'b10);
    check("wr_first_cmd", {bus.m_read, bus.m_write}, 2'b01);
    check("wr_first_bc", bus.m_burstcount, 4);
    check("wr_first_data", bus.m_writedata[63:0], 64'hA0);
    tick();
    set_bc(0, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wr_lock_grant", bus.req_waitrequest, 2'b10);
      check("wr_lock_cmd", {bus.m_read, bus.m_write}, 2'b01);
      check("wr_lock_bc", bus.m_burstcount, 4);
      tick();
    end
    bus.req_write = 2'b00;
    set_bc(1, 2);
    #1;
    check("rd_after_burst_grant", bus.req_waitrequest, 2'b01);
    check("rd_after_burst_cmd", {bus.m_read, bus.m_write}, 2'b10);
    tick();
    bus.req_read = 2'b00;
    bus.m_readdatavalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("burst_rsp", bus.req_readdatavalid, 2'b10);
      tick();
    end
    bus.m_readdatavalid = 1'b0;

    // Fill the tag FIFO, then check full masking and the same-cycle pop bypass.
    set_bc(1, 1);
    bus.req_read = 2'b01;
    n = 0;
    for (int i = 0; i < RSP_DEPTH; i++) begin
      #1;
      if (!bus.req_waitrequest[0]) n++;
      tick();
    end
    check("fill_accepts", n, RSP_DEPTH);
    #1;
    check("full_read_waits", bus.req_waitrequest, 2'b11);
    check("full_no_read", bus.m_read, 1'b0);
    bus.req_write = 2'b10;
    #1;
    check("full_write_grant", bus.req_waitrequest, 2'b01);
    check("full_write_cmd", bus.m_write, 1'b1);
    tick();
    bus.req_write = 2'b00;
    bus.m_readdatavalid = 1'b1;
    #1;
    check("pop_push_rdv", bus.req_readdatavalid, 2'b01);
    check("pop_push_grant", bus.req_waitrequest, 2'b10);
    tick();
    bus.req_read = 2'b00;
    n = 0;
    for (int i = 0; i < RSP_DEPTH; i++) begin
      #1;
      if (bus.req_readdatavalid == 2'b01) n++;
      tick();
    end
    check("drain_beats", n, RSP_DEPTH);
    bus.m_readdatavalid = 1'b0;

    // Bank stall: winner and fields hold, nothing is pushed.
    bus.req_read = 2'b11;
    bus.m_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_wait", bus.req_waitrequest, 2'b11);
      check("stall_addr", bus.m_address, 27'h200);
      check("stall_cmd", bus.m_read, 1'b1);
      tick();
    end
    bus.m_waitrequest = 1'b0;
    #1;
    check("stall_release_grant", bus.req_waitrequest, 2'b01);
    tick();
    bus.req_read = 2'b00;

    // Exactly one tag queued; a second beat is unexpected.
    bus.m_readdatavalid = 1'b1;
    #1;
    check("single_rsp", bus.req_readdatavalid, 2'b10);
    check("err_before", bus.err_unexpected_rsp, 1'b0);
    tick();
    #1;
    check("unexp_no_rdv", bus.req_readdatavalid, 2'b00);
    tick();
    bus.m_readdatavalid = 1'b0;
    #1;
    check("err_set", bus.err_unexpected_rsp, 1'b1);
    tick();
    tick();
    tick();
    check("err_sticky", bus.err_unexpected_rsp, 1'b1);

    // Asynchronous reset mid-cycle with requests active.
    bus.req_read = 2'b11;
    #1;
    check("pre_rst_grant", bus.req_waitrequest, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    check("arst_wait", bus.req_waitrequest, 2'b11);
    check("arst_cmd", {bus.m_read, bus.m_write}, 2'b00);
    check("arst_err", bus.err_unexpected_rsp, 1'b0);
    tick();
    bus.req_read = 2'b00;
    tick();
    rst = 1'b0;
    bus.m_readdatavalid = 1'b1;
    #1;
    check("post_rst_rdv", bus.req_readdatavalid, 2'b00);
    tick();
    bus.m_readdatavalid = 1'b0;
    #1;
    check("post_rst_err", bus.err_unexpected_rsp, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
